mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative RV32M multiply/divide unit sitting directly upstream of the register file write port. It consumes the two register-read operands and the destination address of an M-extension instruction, computes over multiple cycles, and then presents the result with a one-cycle write strobe. The strobe, write address and data are wired straight to the register file's enable, write-address and write-data inputs. While it computes, `busy` stalls the issuing control logic.

## Interface
- `XLEN`, default 32: operand and result width; fixed at 32 for RV32M.
- `clk`  in  1: single clock, rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: launch request; sampled only in IDLE.
- `funct3`  in  3: RV32M op. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`  in  32: operand A (dividend / multiplicand).
- `rs2`  in  32: operand B (divisor / multiplier).
- `rd`  in  5: destination register address.
- `busy`  out  1: high from the cycle after an accepted start through the DONE cycle, inclusive.
- `done`  out  1: one-cycle pulse; `result`/`wa` are valid in that cycle.
- `en`  out  1: register-file write enable, equal to `done`.
- `wa`  out  5: captured `rd`.
- `result`  out  32: computed value; held until the next `done`.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - On `start`=1, capture `funct3`, `rs1`, `rs2`, `rd`.
  - Convert the operands to magnitudes according to signedness. MULH: both signed. MULHSU: rs1 signed, rs2 unsigned. DIV/REM: both signed. Other ops: unsigned.
  - Record the result sign, clear the 6-bit iteration counter, and go to RUN.
- **Special divide cases**, decided in IDLE at capture:
  - Divide by zero (rs2==0): quotient=0xFFFFFFFF, remainder=rs1.
  - Signed overflow (DIV/REM, rs1==0x80000000, rs2==0xFFFFFFFF): quotient=0x80000000, remainder=0.
  - In both cases, load the result and go straight to DONE.
- **RUN, multiply**
  - Radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle, 32 cycles.
- **RUN, divide**
  - Restoring division, one quotient bit per cycle, 32 cycles.
  - 32-bit remainder register plus a 33-bit trial subtract.
- **RUN exit**
  - After iteration 32, apply sign fix-up as a two's complement of the 64-bit product or the quotient/remainder.
  - Product sign: XOR of the operand signs.
  - Quotient sign: XOR of the operand signs. Remainder sign: sign of the dividend.
  - Select the output word: MUL → product[31:0]; MULH* → product[63:32].
  - Register it into `result` and go to DONE.
- **DONE**
  - Assert `done`/`en` for exactly one cycle, then return to IDLE.
  - `start` in DONE is ignored.
- `start` while `busy` is ignored; inputs may change freely while `busy`.
- `wa`=0 is still strobed; the register file discards writes to x0.

## Timing
- Reset values: `busy`=0, `done`=0, `en`=0, `wa`=0, `result`=0, state=IDLE, counter=0.
- Edge E0 accepts `start`. Normal ops assert `done` in the cycle after edge E33, giving a latency of 33 cycles. `busy` is high for 34 cycles.
- Special-case divides assert `done` in the cycle after E1, giving a latency of 1 cycle.
- Earliest next accepted start: the edge ending the DONE cycle plus one. Back-to-back throughput is one op per 35 cycles.
- `rst_n` low mid-operation aborts immediately and asynchronously:
  - all outputs return to reset values;
  - no `done`/`en` is produced for the aborted op.
- `result` and `wa` change only on the edge entering DONE.

## Configuration
- `MULDIV_DIV_EN` defined: all eight ops are supported as above.
- `MULDIV_DIV_EN` undefined:
  - The divider datapath and special-case logic are removed.
  - funct3[2]=1 ops are accepted and go straight to DONE one cycle later with `result`=0.
  - Multiply behaviour and timing are unchanged.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD (-3), rd=5 → `done`/`en` 33 cycles after start, `result`=0xFFFFFFEB, `wa`=5.
- MULH 0x80000000 × 0x80000000 → `result`=0x40000000. MULHU same operands → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → `result`=0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Edge cases:
  - DIV x/0 with x=0x1234 → `result`=0xFFFFFFFF after 1 cycle; REM x/0 → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Start during RUN and start during DONE with different operands → both ignored. The first op's result is unchanged, and exactly one `done` pulse occurs.
- Assert `rst_n`=0 at iteration 10 of a MUL, then release and idle 40 cycles → no `done`, `result`=0, `busy`=0. A subsequent op completes normally.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit feeding the register-file write port.
// Define MULDIV_DIV_EN to include the divider; otherwise divide ops return 0.
module mul_div_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [4:0]      rd,
   output logic            busy,
   output logic            done,
   output logic            en,
   output logic [4:0]      wa,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [5:0]          cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     a_q, a_d;
   logic [2:0]          op_q, op_d;
   logic                neg_q, neg_d;
   logic                spec_q, spec_d;
   logic [4:0]          rd_q, rd_d;
   logic [4:0]          wa_q, wa_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                sgn1, sgn2, neg1, neg2;
   logic [XLEN-1:0]     mag1, mag2;
   logic [XLEN:0]       sum;
   logic [2*XLEN-1:0]   prod;
`ifdef MULDIV_DIV_EN
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   logic [XLEN:0]       shifted;
   logic [XLEN-1:0]     diff;
   logic                ge;
   logic [XLEN-1:0]     word;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         a_q      <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         spec_q   <= 1'b0;
         rd_q     <= '0;
         wa_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         a_q      <= a_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         spec_q   <= spec_d;
         rd_q     <= rd_d;
         wa_q     <= wa_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      a_d      = a_q;
      op_d     = op_q;
      neg_d    = neg_q;
      spec_d   = spec_q;
      rd_d     = rd_q;
      wa_d     = wa_q;
      result_d = result_q;

      sgn1 = (funct3 == 3'b001) || (funct3 == 3'b010) ||
             (funct3 == 3'b100) || (funct3 == 3'b110);
      sgn2 = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      neg1 = sgn1 & rs1[XLEN-1];
      neg2 = sgn2 & rs2[XLEN-1];
      mag1 = neg1 ? -rs1 : rs1;
      mag2 = neg2 ? -rs2 : rs2;

      sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
      prod = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
      shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      ge      = shifted >= {1'b0, a_q};
      diff    = shifted[XLEN-1:0] - a_q;
      word    = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
`endif

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = funct3;
               rd_d    = rd;
               cnt_d   = '0;
               spec_d  = 1'b0;
               state_d = S_RUN;
               if (!funct3[2]) begin
                  a_d   = mag1;
                  acc_d = {{XLEN{1'b0}}, mag2};
                  neg_d = neg1 ^ neg2;
               end else begin
`ifdef MULDIV_DIV_EN
                  a_d   = mag2;
                  acc_d = {{XLEN{1'b0}}, mag1};
                  neg_d = funct3[1] ? neg1 : (neg1 ^ neg2);
                  // Special results are parked in acc and released one edge later.
                  if (rs2 == '0) begin
                     spec_d = 1'b1;
                     acc_d  = {{XLEN{1'b0}}, (funct3[1] ? rs1 : {XLEN{1'b1}})};
                  end else if (!funct3[0] && rs1 == MIN_NEG && rs2 == '1) begin
                     spec_d = 1'b1;
                     acc_d  = {{XLEN{1'b0}}, (funct3[1] ? {XLEN{1'b0}} : MIN_NEG)};
                  end
`else
                  spec_d = 1'b1;
                  acc_d  = '0;
`endif
               end
            end
         end

         S_RUN: begin
            if (spec_q) begin
               result_d = acc_q[XLEN-1:0];
               wa_d     = rd_q;
               state_d  = S_DONE;
            end else if (cnt_q == 6'(XLEN)) begin
               wa_d    = rd_q;
               state_d = S_DONE;
               if (!op_q[2]) begin
                  result_d = (op_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
               end else begin
`ifdef MULDIV_DIV_EN
                  result_d = neg_q ? -word : word;
`else
                  result_d = '0;
`endif
               end
            end else begin
               cnt_d = cnt_q + 6'd1;
               if (!op_q[2]) begin
                  acc_d = {sum, acc_q[XLEN-1:1]};
               end else begin
`ifdef MULDIV_DIV_EN
                  acc_d = {(ge ? diff : shifted[XLEN-1:0]), acc_q[XLEN-2:0], ge};
`endif
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign en     = done;
   assign wa     = wa_q;
   assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases, randomized ops, abort by reset.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic [4:0]  rd = '0;
   logic        busy, done, en;
   logic [4:0]  wa;
   logic [31:0] result;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   logic [31:0] exp_hold = '0;

   mul_div_unit #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
      .rs1(rs1), .rs2(rs2), .rd(rd),
      .busy(busy), .done(done), .en(en), .wa(wa), .result(result)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] p;
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      case (f)
         3'b000: return a * b;
         3'b001: begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return p[63:32];
         end
         3'b010: begin
            p = {{32{a[31]}}, a} * {32'b0, b};
            return p[63:32];
         end
         3'b011: begin
            p = {32'b0, a} * {32'b0, b};
            return p[63:32];
         end
         default: begin
`ifdef MULDIV_DIV_EN
            if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
            if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               return f[1] ? 32'h0 : 32'h8000_0000;
            case (f)
               3'b100:  return sa / sb;
               3'b101:  return a / b;
               3'b110:  return sa % sb;
               default: return a % b;
            endcase
`else
            return 32'h0;
`endif
         end
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b);
      if (!f[2]) return 33;
`ifdef MULDIV_DIV_EN
      if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
      return 33;
`else
      return 1;
`endif
   endfunction

   task automatic scramble();
      funct3 = 3'($urandom);
      rs1    = $urandom;
      rs2    = $urandom;
      rd     = 5'($urandom);
   endtask

   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input bit meddle);
      logic [31:0] exp_r;
      int lat, n, n0, busy_low;
      exp_r = ref_res(f, a, b);
      lat   = ref_lat(f, a, b);
      @(negedge clk);
      funct3 = f; rs1 = a; rs2 = b; rd = r; start = 1'b1;
      @(posedge clk); #1;
      n0 = done_cnt;
      start = meddle;
      scramble();
      chk("busy_after_start", busy, 1);
      chk("result_held_early", result, exp_hold);
      n = 0;
      busy_low = 0;
      while (done !== 1'b1 && n < 60) begin
         @(posedge clk); #1;
         n++;
         if (busy !== 1'b1) busy_low++;
         if (meddle) scramble();
      end
      chk("latency", n, lat);
      chk("busy_through_run", busy_low, 0);
      chk("result", result, exp_r);
      chk("wa", wa, r);
      chk("en", en, 1);
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_single_cycle", done, 0);
      chk("busy_idle", busy, 0);
      chk("result_hold", result, exp_r);
      chk("done_count", done_cnt - n0, 1);
      exp_hold = exp_r;
   endtask

   initial begin
      int n0;
      logic [2:0]  f;
      logic [31:0] a, b;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_en", en, 0);
      chk("rst_wa", wa, 0);
      chk("rst_result", result, 0);
      @(negedge clk) rst_n = 1'b1;

      run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0);
      run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd3, 1'b0);
      run_op(3'b011, 32'h8000_0000, 32'h8000_0000, 5'd4, 1'b0);
      run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b0);
      run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b0);
      run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b0);
      run_op(3'b101, 32'd100, 32'd7, 5'd9, 1'b0);
      run_op(3'b111, 32'd100, 32'd7, 5'd10, 1'b0);
      run_op(3'b100, 32'h1234, 32'd0, 5'd11, 1'b0);
      run_op(3'b110, 32'h1234, 32'd0, 5'd12, 1'b0);
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b0);
      run_op(3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 1'b0);

      // start held high through RUN and DONE with changing operands
      run_op(3'b000, 32'h0001_2345, 32'h0000_6789, 5'd9, 1'b1);
      n0 = done_cnt;
      repeat (40) @(posedge clk);
      #1;
      chk("no_extra_done", done_cnt - n0, 0);
      chk("result_after_meddle", result, exp_hold);

      // asynchronous abort at iteration 10 of a multiply
      @(negedge clk);
      funct3 = 3'b000; rs1 = 32'h1111_1111; rs2 = 32'h2222_2222; rd = 5'd17; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n0 = done_cnt;
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_en", en, 0);
      chk("abort_wa", wa, 0);
      chk("abort_result", result, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt - n0, 0);
      chk("abort_result_idle", result, 0);
      chk("abort_busy_idle", busy, 0);
      exp_hold = '0;
      run_op(3'b001, 32'hFFFF_FFFE, 32'd3, 5'd21, 1'b0);

      for (int i = 0; i < 24; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 7) == 0) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         run_op(f, a, b, 5'($urandom), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
